// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 7-segment display scanner with a built-in hex decoder.
// It adds per-digit decimal point, blank, blink and leading-zero suppression, and
// takes a snapshot of its inputs at each frame start so a frame never tears.
// Ports:
//   clk, rst (async, active-low)   clock and reset
//   en                             scan enable; 0 turns the display dark
//   digits_in[4*DIGITS]            packed nibbles, digit 0 = rightmost
//   dp_in / blank_in / blink_in    per-digit decimal point / force dark / blink
//   lz_suppress                    leading-zero suppression enable
//   seg[8]                         active-high segments, seg[7] = dp
//   an[DIGITS]                     active-high one-hot digit enable
//   frame_tick                     one-cycle pulse after each frame wrap
module seg_scan_ctrl #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned BLINK_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blank_in,
    input  logic [DIGITS-1:0]     blink_in,
    input  logic                  lz_suppress,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    typedef enum logic {OFF, RUN} state_t;

    typedef struct packed {
        logic [4*DIGITS-1:0] digits;
        logic [DIGITS-1:0]   dp;
        logic [DIGITS-1:0]   blank;
        logic [DIGITS-1:0]   blink;
        logic                lz;
    } snap_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [BCNT_W-1:0]   bcnt, bcnt_n;
    logic                bph, bph_n;
    snap_t               snap, snap_n, sample;
    logic [7:0]          seg_n;
    logic [DIGITS-1:0]   an_n;
    logic                tick_n;

    logic                lit;
    logic [DIGITS-1:0]   supp;
    logic                zero_run;
    logic [3:0]          cur_nib;
    logic                cur_dp, cur_blank, cur_blink, cur_supp;

    // Hex nibble to a..g segment pattern
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= OFF;
            cnt        <= '0;
            idx        <= '0;
            bcnt       <= '0;
            bph        <= 1'b0;
            snap       <= '0;
            seg        <= '0;
            an         <= '0;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            idx        <= idx_n;
            bcnt       <= bcnt_n;
            bph        <= bph_n;
            snap       <= snap_n;
            seg        <= seg_n;
            an         <= an_n;
            frame_tick <= tick_n;
        end
    end

    // Next-state scan sequencing, then slot output from the next-state view
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        bcnt_n  = bcnt;
        bph_n   = bph;
        snap_n  = snap;
        tick_n  = 1'b0;
        lit     = 1'b0;
        seg_n   = '0;
        an_n    = '0;

        sample.digits = digits_in;
        sample.dp     = dp_in;
        sample.blank  = blank_in;
        sample.blink  = blink_in;
        sample.lz     = lz_suppress;

        unique case (state)
            OFF: begin
                if (en) begin
                    state_n = RUN;
                    snap_n  = sample;
                    cnt_n   = '0;
                    idx_n   = '0;
                    lit     = 1'b1;
                end
            end
            RUN: begin
                if (!en) begin
                    state_n = OFF;
                    cnt_n   = '0;
                    idx_n   = '0;
                    bcnt_n  = '0;
                    bph_n   = 1'b0;
                end else begin
                    lit = 1'b1;
                    if (cnt == CNT_W'(SCAN_DIV - 1)) begin
                        cnt_n = '0;
                        if (idx == IDX_W'(DIGITS - 1)) begin
                            // Frame wrap: fresh snapshot, tick, advance blink timing
                            idx_n  = '0;
                            snap_n = sample;
                            tick_n = 1'b1;
                            if (bcnt == BCNT_W'(BLINK_FRAMES - 1)) begin
                                bcnt_n = '0;
                                bph_n  = ~bph;
                            end else begin
                                bcnt_n = bcnt + BCNT_W'(1);
                            end
                        end else begin
                            idx_n = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: state_n = OFF;
        endcase

        // A digit is suppressed while every nibble from the top down to it is zero
        supp     = '0;
        zero_run = snap_n.lz;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            zero_run = zero_run && (snap_n.digits[4*i +: 4] == 4'h0);
            supp[i]  = zero_run;
        end

        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        cur_blink = 1'b0;
        cur_supp  = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_n == IDX_W'(i)) begin
                cur_nib   = snap_n.digits[4*i +: 4];
                cur_dp    = snap_n.dp[i];
                cur_blank = snap_n.blank[i];
                cur_blink = snap_n.blink[i];
                cur_supp  = supp[i];
            end
        end

        if (lit && !(cur_blank || (cur_blink && bph_n))) begin
            if (cur_supp) begin
                if (cur_dp) begin
                    an_n  = DIGITS'(1) << idx_n;
                    seg_n = 8'h80;
                end
            end else begin
                an_n  = DIGITS'(1) << idx_n;
                seg_n = {cur_dp, hex7(cur_nib)};
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: a time-based reference model predicts the
// registered outputs after every rising edge and a negedge monitor checks them.
module tb_seg_scan_ctrl;

    localparam int unsigned SD    = 4;
    localparam int unsigned ND    = 4;
    localparam int unsigned BF    = 2;
    localparam int unsigned FRAME = SD * ND;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [15:0]   digits_in;
    logic [3:0]    dp_in, blank_in, blink_in;
    logic          lz_suppress;
    logic [7:0]    seg;
    logic [3:0]    an;
    logic          frame_tick;

    int unsigned   n_cmp  = 0;
    int unsigned   n_fail = 0;

    logic [12:0]   exp_q[$];

    // Reference model state: time since the scan started, frame count, frame snapshot
    bit            m_run = 1'b0;
    int unsigned   m_t, m_frame;
    logic [15:0]   m_dig;
    logic [3:0]    m_dp, m_blank, m_blink;
    logic          m_lz;
    logic [6:0]    dec_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_ctrl #(.SCAN_DIV(SD), .DIGITS(ND), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .en(en), .digits_in(digits_in), .dp_in(dp_in),
        .blank_in(blank_in), .blink_in(blink_in), .lz_suppress(lz_suppress),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t seg/an/tick got %h/%h/%b want %h/%h/%b", name, $time,
                     act[12:5], act[4:1], act[0], exp[12:5], exp[4:1], exp[0]);
        end
    endtask

    function automatic logic [12:0] predict(input logic tick);
        int unsigned slot, hi;
        logic [3:0]  nib;
        logic        bph, supp;
        slot = (m_t % FRAME) / SD;
        bph  = ((m_frame / BF) % 2) == 1;
        hi   = 0;
        for (int i = 0; i < int'(ND); i++) begin
            nib = m_dig[i*4 +: 4];
            if (nib != 4'h0) hi = i;
        end
        supp = m_lz && (slot > hi);
        nib  = m_dig[slot*4 +: 4];
        if (m_blank[slot] || (m_blink[slot] && bph))
            return {8'h00, 4'h0, tick};
        if (supp)
            return m_dp[slot] ? {8'h80, 4'(1 << slot), tick} : {8'h00, 4'h0, tick};
        return {m_dp[slot], dec_tbl[nib], 4'(1 << slot), tick};
    endfunction

    // Reference model: advance on each rising edge and queue the expected outputs
    always @(posedge clk) begin
        logic tick;
        tick = 1'b0;
        if (!rst) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; m_t = 0; m_frame = 0;
                m_dig = digits_in; m_dp = dp_in; m_blank = blank_in;
                m_blink = blink_in; m_lz = lz_suppress;
            end
        end else if (!en) begin
            m_run = 1'b0;
        end else begin
            m_t++;
            if (m_t % FRAME == 0) begin
                m_frame++; tick = 1'b1;
                m_dig = digits_in; m_dp = dp_in; m_blank = blank_in;
                m_blink = blink_in; m_lz = lz_suppress;
            end
        end
        exp_q.push_back(m_run ? predict(tick) : 13'h0);
    end

    // Monitor: compare DUT outputs against the oldest prediction
    always @(negedge clk) begin
        logic [12:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scan", {seg, an, frame_tick}, e);
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; digits_in = '0; dp_in = '0; blank_in = '0;
        blink_in = '0; lz_suppress = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(2);

        // Basic scan of 4321, then a mid-frame change that must stay invisible
        digits_in = 16'h4321; en = 1'b1;
        cyc(FRAME + 5);
        digits_in = 16'h8888;
        cyc(2 * FRAME);

        // Leading-zero suppression
        lz_suppress = 1'b1; digits_in = 16'h0050;
        cyc(2 * FRAME + 3);
        digits_in = 16'h0000;
        cyc(2 * FRAME);
        lz_suppress = 1'b0;

        // Blinking digit 0 over several blink phases
        blink_in = 4'b0001;
        cyc(7 * FRAME);
        blink_in = 4'b0000;

        // Decimal points with a blanked digit
        dp_in = 4'b1010; blank_in = 4'b1000; digits_in = 16'h9ABC;
        cyc(2 * FRAME);
        lz_suppress = 1'b1; digits_in = 16'h0007;
        cyc(2 * FRAME);
        dp_in = '0; blank_in = '0; lz_suppress = 1'b0;

        // Enable drop and restart mid-frame
        cyc(FRAME + 9);
        en = 1'b0;
        cyc(3);
        en = 1'b1;
        cyc(FRAME + 6);

        // Asynchronous reset mid-slot
        rst = 1'b0;
        #1;
        check("async_rst", {seg, an, frame_tick}, 13'h0);
        cyc(2);
        rst = 1'b1;
        cyc(FRAME + 4);

        // Randomised traffic
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 9) == 0) digits_in = 16'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                dp_in = 4'($urandom); blank_in = 4'($urandom & $urandom);
                blink_in = 4'($urandom); lz_suppress = 1'($urandom);
            end
            if ($urandom_range(0, 59) == 0) en = ~en;
            cyc(1);
        end

        cyc(2);
        n_cmp++;
        if (exp_q.size() > 1) begin
            n_fail++;
            $display("FAIL drain pending=%0d want<=1", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
